// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit_pkg : shared state encodings and constants for the fetch unit
// Revision: 1.0
// ============================================================================
package fetch_pc_unit_pkg;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_ISSUE = 3'd1,
    FS_WAIT  = 3'd2,
    FS_OUT   = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [4:0]  OP_HALT  = 5'b00000;
  localparam logic [15:0] PC_STEP  = 16'd2;

  // Instructions are halfword aligned; odd targets drop bit 0.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_incr.sv
`default_nettype none
// ============================================================================
// pc_incr : 16-bit carry-lookahead adder with b fixed to PC_STEP, c_in = 0
// Revision: 1.0
// ============================================================================
module pc_incr
  import fetch_pc_unit_pkg::*;
(
  input  logic [15:0] a,
  output logic [15:0] sum
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [16:0] carry;

  assign gen      = a & PC_STEP;
  assign prop     = a ^ PC_STEP;
  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_carry
      assign carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  endgenerate

  // Carry out of bit 15 is dropped so the PC wraps.
  assign sum = prop ^ carry[15:0];

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit : PC owner, single-outstanding imem fetch, decode handoff
// Revision: 1.0
// ============================================================================
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_vld,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        inst_vld,
  input  logic        inst_rdy,
  output logic [15:0] inst,
  output logic [15:0] pc,
  output logic [15:0] incPC,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_state_t  state;
  logic [15:0]   pc_reg;
  logic [15:0]   inc_pc_reg;
  logic [15:0]   inst_reg;
  logic          squash;
  logic [CW-1:0] wait_cnt;
  logic          err_reg;

  logic [15:0]   tgt_pc;
  logic [15:0]   tgt_inc;
  logic [15:0]   seq_inc;
  logic [CW-1:0] cnt_nxt;
  logic          timeout_hit;

  assign tgt_pc      = align_pc(redirect_pc);
  assign cnt_nxt     = wait_cnt + CW'(1);
  assign timeout_hit = (cnt_nxt == CW'(TIMEOUT));

  pc_incr u_tgt_incr (.a(tgt_pc),     .sum(tgt_inc));
  pc_incr u_seq_incr (.a(inc_pc_reg), .sum(seq_inc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FS_IDLE;
      pc_reg     <= RESET_PC;
      inc_pc_reg <= RESET_PC + PC_STEP;
      inst_reg   <= NOP_INST;
      squash     <= 1'b0;
      wait_cnt   <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (redirect_vld) begin
            pc_reg     <= tgt_pc;
            inc_pc_reg <= tgt_inc;
          end
          state <= FS_ISSUE;
        end
        FS_ISSUE: begin
          if (redirect_vld) begin
            pc_reg     <= tgt_pc;
            inc_pc_reg <= tgt_inc;
          end
          if (imem_gnt) begin
            state    <= FS_WAIT;
            wait_cnt <= '0;
            // The granted request was for the old path; its response is dropped.
            if (redirect_vld) squash <= 1'b1;
          end
        end
        FS_WAIT: begin
          wait_cnt <= cnt_nxt;
          if (imem_rvalid) begin
            if (redirect_vld) begin
              pc_reg     <= tgt_pc;
              inc_pc_reg <= tgt_inc;
              squash     <= 1'b0;
              state      <= FS_ISSUE;
            end else if (squash) begin
              squash <= 1'b0;
              state  <= FS_ISSUE;
            end else begin
              inst_reg <= imem_rdata;
              state    <= FS_OUT;
            end
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
            state   <= FS_HALT;
          end else if (redirect_vld) begin
            pc_reg     <= tgt_pc;
            inc_pc_reg <= tgt_inc;
            squash     <= 1'b1;
          end
        end
        FS_OUT: begin
          if (redirect_vld) begin
            pc_reg     <= tgt_pc;
            inc_pc_reg <= tgt_inc;
            state      <= FS_ISSUE;
          end else if (inst_rdy) begin
            pc_reg     <= inc_pc_reg;
            inc_pc_reg <= seq_inc;
            state      <= (inst_reg[15:11] == OP_HALT) ? FS_HALT : FS_ISSUE;
          end
        end
        FS_HALT: begin
        end
        default: state <= FS_HALT;
      endcase
    end
  end

  assign imem_req  = (state == FS_ISSUE);
  assign imem_addr = pc_reg;
  assign inst_vld  = (state == FS_OUT);
  assign inst      = inst_reg;
  assign pc        = pc_reg;
  assign incPC     = inc_pc_reg;
  assign busy      = (state == FS_ISSUE) || (state == FS_WAIT);
  assign err       = err_reg;

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Front end of the WISC-F24 pipeline-ready datapath. It owns the PC register and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It presents each fetched instruction to decode over a valid/ready pair. It consumes the execute stage's redirect, the newPC target, and squashes any in-flight or held instruction from the wrong path.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
TIMEOUT, 64, max cycles in WAIT without imem_rvalid before err is raised (counter width $clog2(TIMEOUT+1)).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
redirect_vld  in  1  execute requests a PC change this cycle
redirect_pc  in  16  target PC from execute (newPC)
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch address (= pc while imem_req)
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid, one cycle pulse
imem_rdata  in  16  instruction word
inst_vld  out  1  instruction held for decode
inst_rdy  in  1  decode accepts the instruction
inst  out  16  instruction word to decode
pc  out  16  address of the instruction being fetched or held
incPC  out  16  pc + 2, paired with inst
busy  out  1  high in ISSUE or WAIT
err  out  1  sticky fetch timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=RESET_PC, incPC=RESET_PC+2, inst=16'h0800 (NOP), inst_vld=0, imem_req=0, squash=0, wait counter=0, err=0.
- States are IDLE, ISSUE, WAIT, OUT and HALT. imem_req=1 only in ISSUE. inst_vld=1 only in OUT.
- IDLE: go to ISSUE the next cycle unconditionally. A redirect in IDLE loads pc and still goes to ISSUE.
- ISSUE: drive imem_addr=pc.
  - On imem_gnt, go to WAIT and clear the counter.
  - On redirect_vld without gnt, load pc and stay in ISSUE.
  - On redirect_vld with gnt in the same cycle, load pc, set squash=1 and go to WAIT.
- WAIT: the counter increments each cycle.
  - On imem_rvalid with squash=0: latch inst=imem_rdata and go to OUT.
  - On imem_rvalid with squash=1: discard the data, clear squash and go to ISSUE.
  - On redirect_vld: load pc and set squash=1. If imem_rvalid arrives in the same cycle, discard the data, keep squash=0 and go to ISSUE.
  - If the counter reaches TIMEOUT with no rvalid: set err=1 and go to HALT.
- OUT: inst, pc and incPC are held stable while inst_rdy=0.
  - On inst_rdy: pc<=incPC and incPC<=incPC+2.
    - If inst[15:11]==5'b00000 (HALT), go to HALT.
    - Otherwise go to ISSUE.
  - On redirect_vld: drop the held instruction, load pc, deassert inst_vld next cycle and go to ISSUE. Redirect beats inst_rdy in the same cycle.
- HALT: no requests, inst_vld=0, redirects ignored. Only reset exits.
- Redirect load:
  - pc<={redirect_pc[15:1],1'b0}; an odd target is silently aligned.
  - incPC<=aligned target+2.
- Arithmetic: 16-bit unsigned, wraps (16'hFFFE+2=16'h0000), no carry out.
- Latency: minimum 3 cycles from entering ISSUE to inst_vld (ISSUE with gnt, WAIT with rvalid, OUT). Throughput is at most one instruction per 3 cycles; there is one outstanding request.
- An imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared package/include (fetch_defs.vh):
  - state encodings FS_IDLE=3'd0, FS_ISSUE=3'd1, FS_WAIT=3'd2, FS_OUT=3'd3, FS_HALT=3'd4
  - NOP_INST=16'h0800
  - OP_HALT=5'b00000
  - PC_STEP=16'd2
- Sub-module: pc_incr (16-bit +2 adder wrapping cla_16b with b=16'h0002, c_in=0), used for incPC generation.

Test Plan:
- Reset release, gnt and rvalid asserted 1 cycle after each request, inst_rdy=1, rdata=16'h4000,16'h4000,16'h0000 -> imem_addr sequence 0x0000,0x0002,0x0004; three inst_vld pulses with pc 0,2,4 and incPC 2,4,6; HALT reached with imem_req=0 forever.
- Redirect to 16'h0100 in the same cycle as gnt for pc=0x0002 -> response for 0x0002 discarded with inst_vld staying 0; next imem_addr=0x0100.
- Held instruction in OUT with inst_rdy=0 for 5 cycles -> inst/pc stable. Then redirect_vld and inst_rdy together with redirect_pc=16'h0041 -> instruction dropped, next imem_addr=0x0040, incPC=0x0042.
- Redirect to 16'hFFFE, then accept that instruction -> next imem_addr=16'h0000 (wrap).
- Withhold imem_rvalid for TIMEOUT=64 cycles after gnt -> err=1 on cycle 64, state HALT, later rvalid ignored.
- Assert rst_n=0 mid-WAIT with squash set -> outputs return asynchronously to reset values; after release, first imem_addr=RESET_PC and err=0.
